// File: rtl/data_frames_pkg.sv
// -----------------------------------------------------------------------------
// data_frames : shared frame definitions for the pulse-ID link.
//   PULSE_ID_TYPE   payload type code carrying a 64-bit pulse-ID (the
//                   generator uses the same constant).
//   payload_t       decoded payload: 8-bit type followed by 64-bit data.
//   checker_state_t lock state of the receiver-side pulse-ID checker.
// -----------------------------------------------------------------------------
package data_frames;

  localparam logic [7:0] PULSE_ID_TYPE = 8'h01;

  typedef struct packed {
    logic [7:0]  payload_type;
    logic [63:0] data;
  } payload_t;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2
  } checker_state_t;

endpackage

// File: rtl/pulse_id_checker_fifo.sv
// -----------------------------------------------------------------------------
// sync_payload_fifo : single-clock first-word-fall-through FIFO.
//   clk, reset  clock and synchronous active-high reset (empties the FIFO)
//   push_i      write data_i (accepted when not full, or full with a pop)
//   data_i      write data
//   pop_i       consume the head entry (ignored when empty)
//   data_o      head entry, zero while empty
//   full_o      DEPTH entries stored
//   empty_o     no entries stored
// -----------------------------------------------------------------------------
module sync_payload_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push_s;
  logic                  do_pop_s;

  // count never exceeds DEPTH, so its MSB alone flags full
  assign full_o  = count_q[DEPTH_LOG2];
  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // a pop frees a slot in the same cycle, so full + pop still accepts a push
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: entries are only visible between the pointers
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pulse_id_checker.sv
// -----------------------------------------------------------------------------
// pulse_id_checker : tracks the broadcast pulse-ID, checks +1 continuity,
// counts missed IDs, detects loss of the stream and forwards every other
// payload through a small FWFT buffer.
//   clk, reset             80 MHz word clock, synchronous active-high reset
//   payload_valid_i/_i     decoded payload strobe and data (payload_t)
//   clear_stats_i          zero counters and sticky flags
//   pulse_id_o/_strobe_o   last accepted ID and its one-cycle strobe
//   locked_o               in LOCKED state
//   seq_error_o            sticky, discontinuity while LOCKED
//   timeout_o              sticky, LOCKED lost by timeout
//   missed_count_o         saturating count of skipped IDs
//   fwd_overflow_count_o   saturating count of dropped forward payloads
//   fwd_valid_o/_payload_o head of forward buffer, popped by fwd_ready_i
// Optional: define PULSE_ID_CHECKER_PERIOD_EN to add period_o, the number of
// clk cycles between the last two accepted IDs (saturating, 0 until two IDs).
// -----------------------------------------------------------------------------
module pulse_id_checker
  import data_frames::*;
#(
  parameter int LOCK_COUNT     = 3,
  parameter int MAX_GAP        = 1000,
  parameter int TIMEOUT_CYCLES = 1_200_000,
  parameter int FWD_DEPTH_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       payload_valid_i,
  input  logic [$bits(payload_t)-1:0] payload_i,
  input  logic                       clear_stats_i,
  output logic [63:0]                pulse_id_o,
  output logic                       pulse_id_strobe_o,
  output logic                       locked_o,
  output logic                       seq_error_o,
  output logic                       timeout_o,
  output logic [31:0]                missed_count_o,
  output logic [15:0]                fwd_overflow_count_o,
  output logic                       fwd_valid_o,
  output logic [$bits(payload_t)-1:0] fwd_payload_o,
  input  logic                       fwd_ready_i
`ifdef PULSE_ID_CHECKER_PERIOD_EN
  ,
  output logic [31:0]                period_o
`endif
);

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] TIMEOUT_M1  = 32'(TIMEOUT_CYCLES - 1);

  checker_state_t state_q, state_d;
  logic [63:0] last_q, last_d;
  logic [3:0]  match_q, match_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] missed_q, missed_d;
  logic [15:0] ovf_q, ovf_d;
  logic        seq_err_q, seq_err_d;
  logic        timeout_q, timeout_d;
  logic        strobe_q, strobe_d;

  payload_t    payload_s;
  logic        is_id_s;
  logic [63:0] exp_s;
  logic [63:0] diff_s;
  logic [32:0] missed_sum_s;
  logic [3:0]  match_inc_s;
  logic        fwd_push_s;
  logic        fwd_full_s;
  logic        fwd_empty_s;
  logic        fwd_drop_s;

  assign payload_s    = payload_t'(payload_i);
  assign is_id_s      = payload_valid_i && (payload_s.payload_type == PULSE_ID_TYPE);
  assign exp_s        = last_q + 64'd1;
  // forward jump beyond the expected ID; wraps naturally mod 2^64
  assign diff_s       = payload_s.data - exp_s;
  assign missed_sum_s = {1'b0, missed_q} + {1'b0, diff_s[31:0]};
  assign match_inc_s  = match_q + 4'd1;

  assign fwd_push_s = payload_valid_i & ~is_id_s;
  // full implies non-empty, so fwd_ready_i alone means a pop frees a slot
  assign fwd_drop_s = fwd_push_s & fwd_full_s & ~fwd_ready_i;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    match_d   = match_q;
    idle_d    = idle_q;
    missed_d  = missed_q;
    ovf_d     = ovf_q;
    seq_err_d = seq_err_q;
    timeout_d = timeout_q;
    strobe_d  = 1'b0;

    if (is_id_s) begin
      idle_d   = 32'd0;
      strobe_d = 1'b1;
      last_d   = payload_s.data;
      case (state_q)
        UNLOCKED: begin
          match_d = 4'd1;
          state_d = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRING;
        end
        ACQUIRING: begin
          if (payload_s.data == exp_s) begin
            match_d = match_inc_s;
            if (match_inc_s >= 4'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            match_d = 4'd1;
          end
        end
        LOCKED: begin
          if (diff_s == 64'd0) begin
            state_d = LOCKED;
          end else if (diff_s <= 64'(MAX_GAP)) begin
            missed_d = missed_sum_s[32] ? 32'hFFFF_FFFF : missed_sum_s[31:0];
          end else begin
            seq_err_d = 1'b1;
            match_d   = 4'd1;
            state_d   = ACQUIRING;
          end
        end
        default: begin
          match_d = 4'd1;
          state_d = ACQUIRING;
        end
      endcase
    end else begin
      // idle timer holds at the limit so timeout only fires on the crossing
      if (idle_q != TIMEOUT_LIM) idle_d = idle_q + 32'd1;
      if (idle_q == TIMEOUT_M1) begin
        if (state_q == LOCKED) begin
          timeout_d = 1'b1;
          state_d   = UNLOCKED;
        end else if (state_q == ACQUIRING) begin
          state_d = UNLOCKED;
        end
      end
    end

    if (fwd_drop_s && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;

    // clear wins over any same-cycle increment or flag set
    if (clear_stats_i) begin
      missed_d  = 32'd0;
      ovf_d     = 16'd0;
      seq_err_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      last_q    <= 64'd0;
      match_q   <= 4'd0;
      idle_q    <= 32'd0;
      missed_q  <= 32'd0;
      ovf_q     <= 16'd0;
      seq_err_q <= 1'b0;
      timeout_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      match_q   <= match_d;
      idle_q    <= idle_d;
      missed_q  <= missed_d;
      ovf_q     <= ovf_d;
      seq_err_q <= seq_err_d;
      timeout_q <= timeout_d;
      strobe_q  <= strobe_d;
    end
  end

  assign pulse_id_o           = last_q;
  assign pulse_id_strobe_o    = strobe_q;
  assign locked_o             = (state_q == LOCKED);
  assign seq_error_o          = seq_err_q;
  assign timeout_o            = timeout_q;
  assign missed_count_o       = missed_q;
  assign fwd_overflow_count_o = ovf_q;
  assign fwd_valid_o          = ~fwd_empty_s;

  sync_payload_fifo #(
    .DEPTH_LOG2 (FWD_DEPTH_LOG2),
    .WIDTH      ($bits(payload_t))
  ) u_fwd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fwd_push_s),
    .data_i  (payload_i),
    .pop_i   (fwd_ready_i),
    .data_o  (fwd_payload_o),
    .full_o  (fwd_full_s),
    .empty_o (fwd_empty_s)
  );

`ifdef PULSE_ID_CHECKER_PERIOD_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] period_q, period_d;
  logic        seen_q, seen_d;
  logic [31:0] cyc_inc_s;

  assign cyc_inc_s = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  always_comb begin
    cyc_d    = cyc_inc_s;
    period_d = period_q;
    seen_d   = seen_q;
    if (is_id_s) begin
      cyc_d    = 32'd0;
      seen_d   = 1'b1;
      period_d = seen_q ? cyc_inc_s : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q    <= 32'd0;
      period_q <= 32'd0;
      seen_q   <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      period_q <= period_d;
      seen_q   <= seen_d;
    end
  end

  assign period_o = period_q;
`endif

endmodule

// File: tb/tb_pulse_id_checker.sv
module tb_pulse_id_checker;
  import data_frames::*;

  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         payload_valid_i;
  logic [71:0]  payload_i;
  logic         clear_stats_i;
  logic [63:0]  pulse_id_o;
  logic         pulse_id_strobe_o;
  logic         locked_o;
  logic         seq_error_o;
  logic         timeout_o;
  logic [31:0]  missed_count_o;
  logic [15:0]  fwd_overflow_count_o;
  logic         fwd_valid_o;
  logic [71:0]  fwd_payload_o;
  logic         fwd_ready_i;
`ifdef PULSE_ID_CHECKER_PERIOD_EN
  logic [31:0]  period_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_id_checker #(
    .LOCK_COUNT     (3),
    .MAX_GAP        (1000),
    .TIMEOUT_CYCLES (TMO),
    .FWD_DEPTH_LOG2 (3)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .payload_valid_i      (payload_valid_i),
    .payload_i            (payload_i),
    .clear_stats_i        (clear_stats_i),
    .pulse_id_o           (pulse_id_o),
    .pulse_id_strobe_o    (pulse_id_strobe_o),
    .locked_o             (locked_o),
    .seq_error_o          (seq_error_o),
    .timeout_o            (timeout_o),
    .missed_count_o       (missed_count_o),
    .fwd_overflow_count_o (fwd_overflow_count_o),
    .fwd_valid_o          (fwd_valid_o),
    .fwd_payload_o        (fwd_payload_o),
    .fwd_ready_i          (fwd_ready_i)
`ifdef PULSE_ID_CHECKER_PERIOD_EN
    ,
    .period_o             (period_o)
`endif
  );

  // one payload held for exactly one cycle; returns #1 after the sampling edge
  task automatic send(input logic [7:0] t, input logic [63:0] d,
                      input logic rdy, input logic clr);
    @(posedge clk); #1;
    payload_valid_i = 1'b1;
    payload_i       = {t, d};
    fwd_ready_i     = rdy;
    clear_stats_i   = clr;
    @(posedge clk); #1;
    payload_valid_i = 1'b0;
    payload_i       = 72'd0;
    fwd_ready_i     = 1'b0;
    clear_stats_i   = 1'b0;
  endtask

  task automatic send_id(input logic [63:0] d);
    send(8'h01, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; payload_valid_i = 1'b0; payload_i = 72'd0;
    clear_stats_i = 1'b0; fwd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({pulse_id_o, pulse_id_strobe_o, locked_o, seq_error_o, timeout_o,
         missed_count_o, fwd_overflow_count_o, fwd_valid_o, fwd_payload_o} !== 190'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got id=%0h lk=%0b se=%0b to=%0b miss=%0d ovf=%0d fv=%0b required all 0",
               pulse_id_o, locked_o, seq_error_o, timeout_o, missed_count_o,
               fwd_overflow_count_o, fwd_valid_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    send_id(64'd100);
    repeat (5) @(posedge clk);
    send_id(64'd101);
    n_tests++;
    if (locked_o !== 1'b0) begin n_fail++; $display("FAIL lock_early got %0b required 0", locked_o); end
    repeat (5) @(posedge clk);
    send_id(64'd102);
    n_tests++;
    if (locked_o !== 1'b1) begin n_fail++; $display("FAIL lock_third got %0b required 1", locked_o); end
    n_tests++;
    if (pulse_id_o !== 64'd102) begin n_fail++; $display("FAIL lock_id got %0d required 102", pulse_id_o); end
    n_tests++;
    if (pulse_id_strobe_o !== 1'b1) begin n_fail++; $display("FAIL strobe_hi got %0b required 1", pulse_id_strobe_o); end
    n_tests++;
    if ({missed_count_o, seq_error_o, fwd_valid_o} !== 34'd0) begin
      n_fail++; $display("FAIL lock_clean got miss=%0d se=%0b fv=%0b required 0 0 0",
                         missed_count_o, seq_error_o, fwd_valid_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if (pulse_id_strobe_o !== 1'b0) begin n_fail++; $display("FAIL strobe_lo got %0b required 0", pulse_id_strobe_o); end
  endtask

  // continues from LOCKED at 102
  task automatic test_gap();
    send_id(64'd106);
    n_tests++;
    if (missed_count_o !== 32'd3 || locked_o !== 1'b1) begin
      n_fail++; $display("FAIL gap_missed got miss=%0d lk=%0b required 3 1", missed_count_o, locked_o);
    end
    send_id(64'd50);
    n_tests++;
    if (seq_error_o !== 1'b1 || locked_o !== 1'b0) begin
      n_fail++; $display("FAIL backward got se=%0b lk=%0b required 1 0", seq_error_o, locked_o);
    end
    send_id(64'd51);
    n_tests++;
    if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reacq_51 got %0b required 0", locked_o); end
    send_id(64'd52);
    n_tests++;
    if (locked_o !== 1'b1 || missed_count_o !== 32'd3 || pulse_id_o !== 64'd52) begin
      n_fail++; $display("FAIL reacq_52 got lk=%0b miss=%0d id=%0d required 1 3 52",
                         locked_o, missed_count_o, pulse_id_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send_id(64'hFFFF_FFFF_FFFF_FFFC);
    send_id(64'hFFFF_FFFF_FFFF_FFFD);
    send_id(64'hFFFF_FFFF_FFFF_FFFE);
    send_id(64'hFFFF_FFFF_FFFF_FFFF);
    send_id(64'd0);
    n_tests++;
    if (locked_o !== 1'b1 || pulse_id_o !== 64'd0) begin
      n_fail++; $display("FAIL wrap_zero got lk=%0b id=%0h required 1 0", locked_o, pulse_id_o);
    end
    send_id(64'd1);
    n_tests++;
    if ({locked_o, seq_error_o, missed_count_o, pulse_id_o} !== {1'b1, 1'b0, 32'd0, 64'd1}) begin
      n_fail++; $display("FAIL wrap_one got lk=%0b se=%0b miss=%0d id=%0h required 1 0 0 1",
                         locked_o, seq_error_o, missed_count_o, pulse_id_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_id(64'd1); send_id(64'd2); send_id(64'd3);
    repeat (TMO - 1) @(posedge clk);
    #1;
    n_tests++;
    if (locked_o !== 1'b1 || timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_before got lk=%0b to=%0b required 1 0", locked_o, timeout_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if (locked_o !== 1'b0 || timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL tmo_fire got lk=%0b to=%0b required 0 1", locked_o, timeout_o);
    end
    // ACQUIRING timeout: back to UNLOCKED without a flag, so 12 does not lock
    send(8'h02, 64'd0, 1'b1, 1'b1);
    send_id(64'd10); send_id(64'd11);
    repeat (TMO) @(posedge clk);
    send_id(64'd12);
    n_tests++;
    if (locked_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_acq got lk=%0b to=%0b required 0 0", locked_o, timeout_o);
    end
  endtask

  task automatic test_fifo();
    logic [63:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h02, 64'(i + 16), 1'b0, 1'b0);
    n_tests++;
    if (fwd_overflow_count_o !== 16'd1 || fwd_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL fifo_ovf got ovf=%0d fv=%0b required 1 1", fwd_overflow_count_o, fwd_valid_o);
    end
    // full with same-cycle pop: write accepted, 16 leaves
    send(8'h05, 64'd99, 1'b1, 1'b0);
    n_tests++;
    if (fwd_overflow_count_o !== 16'd1) begin
      n_fail++; $display("FAIL fifo_fullpop got ovf=%0d required 1", fwd_overflow_count_o);
    end
    for (int i = 1; i < 8; i++) exp_q.push_back(64'(i + 16));
    fwd_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (fwd_valid_o !== 1'b1 || fwd_payload_o !== {8'h02, exp_q[i]}) begin
        n_fail++; $display("FAIL fifo_order[%0d] got v=%0b %0h required 02%016h", i, fwd_valid_o, fwd_payload_o, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (fwd_payload_o !== {8'h05, 64'd99}) begin
      n_fail++; $display("FAIL fifo_last got %0h required 05..63", fwd_payload_o);
    end
    @(posedge clk); #1;
    fwd_ready_i = 1'b0;
    n_tests++;
    if (fwd_valid_o !== 1'b0) begin n_fail++; $display("FAIL fifo_empty got %0b required 0", fwd_valid_o); end
  endtask

  task automatic test_clear();
    do_reset();
    send_id(64'd1); send_id(64'd2); send_id(64'd3);
    send_id(64'd3);
    n_tests++;
    if (seq_error_o !== 1'b1) begin n_fail++; $display("FAIL repeat_err got %0b required 1", seq_error_o); end
    send_id(64'd4); send_id(64'd5);
    send(8'h01, 64'd9, 1'b0, 1'b1);
    n_tests++;
    if ({missed_count_o, seq_error_o, timeout_o, locked_o, pulse_id_o} !== {32'd0, 1'b0, 1'b0, 1'b1, 64'd9}) begin
      n_fail++; $display("FAIL clear_wins got miss=%0d se=%0b to=%0b lk=%0b id=%0d required 0 0 0 1 9",
                         missed_count_o, seq_error_o, timeout_o, locked_o, pulse_id_o);
    end
    send_id(64'd11);
    n_tests++;
    if (missed_count_o !== 32'd1) begin n_fail++; $display("FAIL after_clear got %0d required 1", missed_count_o); end
  endtask

  task automatic test_mid_reset();
    send(8'h03, 64'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if ({pulse_id_o, locked_o, seq_error_o, timeout_o, missed_count_o,
         fwd_overflow_count_o, fwd_valid_o, fwd_payload_o} !== 189'd0) begin
      n_fail++; $display("FAIL mid_reset got id=%0d lk=%0b miss=%0d fv=%0b required all 0",
                         pulse_id_o, locked_o, missed_count_o, fwd_valid_o);
    end
    // still UNLOCKED: a single ID must not lock
    send_id(64'd12);
    n_tests++;
    if (locked_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state got %0b required 0", locked_o); end
  endtask

`ifdef PULSE_ID_CHECKER_PERIOD_EN
  task automatic test_period();
    do_reset();
    send_id(64'd1);
    n_tests++;
    if (period_o !== 32'd0) begin n_fail++; $display("FAIL period_first got %0d required 0", period_o); end
    repeat (3) @(posedge clk);
    send_id(64'd2);
    n_tests++;
    if (period_o !== 32'd5) begin n_fail++; $display("FAIL period_val got %0d required 5", period_o); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; payload_valid_i = 1'b0; payload_i = 72'd0;
    clear_stats_i = 1'b0; fwd_ready_i = 1'b0;
    test_reset();
    test_lock();
    test_gap();
    test_wrap();
    test_timeout();
    test_fifo();
    test_clear();
    test_mid_reset();
`ifdef PULSE_ID_CHECKER_PERIOD_EN
    test_period();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
